// File: rtl/symbol_matrix_writer.sv
// symbol_matrix_writer
//
// Purpose:
//   Streams one reel symbol, row by row, from the combinational symbol ROM
//   to a MAX7219-style 8x8 LED matrix driver over a 3-wire serial link.
//   After reset it sends the driver's five-frame init sequence. After that,
//   each accepted start pulse redraws the matrix with eight row frames.
//
// Parameters:
//   CLK_DIV    system clocks per ser_clk half-period (>= 1)
//   INTENSITY  brightness value sent in the intensity init frame (reg 0x0A)
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous, active-high reset
//   start          in   one-cycle pulse requesting a draw of symbol_in
//   symbol_in      in   [2:0] symbol to draw, sampled when start is accepted
//   busy           out  high while initialising or drawing; start ignored
//   done           out  one-cycle pulse after the last row frame of a draw
//   rom_symbol_id  out  [2:0] symbol address to the ROM, held for a draw
//   rom_row_idx    out  [2:0] row address to the ROM
//   rom_pixels     in   [7:0] combinational ROM response for the row
//   ser_clk        out  serial clock, idles low, device samples on rise
//   ser_data       out  serial data, MSB first, low between frames
//   ser_cs_n       out  chip select, idles high, rising edge latches a frame
//
// Every frame is {4'h0, addr[3:0], data[7:0]} and takes 1 + 33*CLK_DIV
// clocks: one LOAD cycle, 16 bits of 2*CLK_DIV clocks each, then a
// CLK_DIV-cycle gap with chip select high.

module symbol_matrix_writer #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] symbol_in,
  output logic       busy,
  output logic       done,
  output logic [2:0] rom_symbol_id,
  output logic [2:0] rom_row_idx,
  input  logic [7:0] rom_pixels,
  output logic       ser_clk,
  output logic       ser_data,
  output logic       ser_cs_n
);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ROWS
  } state_t;

  typedef enum logic [1:0] {
    PH_LOAD,
    PH_SHIFT,
    PH_GAP
  } phase_t;

  localparam int              DW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [2:0]      INIT_LAST = 3'd4;

  state_t        state;
  phase_t        phase;
  logic [2:0]    frame_idx;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [15:0]   shift_reg;
  logic [15:0]   load_word;

  // Driver init sequence: test mode off, no BCD decode, intensity,
  // scan all 8 digits, leave shutdown.
  function automatic logic [15:0] init_word(input logic [2:0] idx);
    logic [15:0] w;
    case (idx)
      3'd0:    w = 16'h0F00;
      3'd1:    w = 16'h0900;
      3'd2:    w = {12'h0A0, INTENSITY};
      3'd3:    w = 16'h0B07;
      default: w = 16'h0C01;
    endcase
    return w;
  endfunction

  // Word captured at LOAD. Row frames address digit registers 1..8, so
  // the register address is the current row index plus one.
  always_comb begin
    load_word = 16'h0000;
    if (state == ST_ROWS) begin
      load_word = {4'h0, {1'b0, rom_row_idx} + 4'd1, rom_pixels};
    end else begin
      load_word = init_word(frame_idx);
    end
  end

  // The top bit of the shift register is the serial output. The register
  // is cleared at the end of every frame, so data sits low between frames.
  assign ser_data = shift_reg[15];

  // Single FSM. The outer state chooses the frame source (init table or
  // ROM rows). The inner phase walks the LOAD / SHIFT / GAP frame timing.
  // Within SHIFT, each bit is clocked out as CLK_DIV cycles with ser_clk
  // low, then CLK_DIV cycles with ser_clk high. The next bit is presented
  // on the falling edge, so data never moves across a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_INIT;
      phase         <= PH_LOAD;
      frame_idx     <= 3'd0;
      div_cnt       <= '0;
      bit_cnt       <= 4'd0;
      shift_reg     <= 16'h0000;
      busy          <= 1'b1;
      done          <= 1'b0;
      rom_symbol_id <= 3'd0;
      rom_row_idx   <= 3'd0;
      ser_clk       <= 1'b0;
      ser_cs_n      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_symbol_id <= symbol_in;
            rom_row_idx   <= 3'd0;
            busy          <= 1'b1;
            phase         <= PH_LOAD;
            div_cnt       <= '0;
            state         <= ST_ROWS;
          end
        end

        ST_INIT, ST_ROWS: begin
          case (phase)
            PH_LOAD: begin
              shift_reg <= load_word;
              ser_cs_n  <= 1'b0;
              ser_clk   <= 1'b0;
              div_cnt   <= '0;
              bit_cnt   <= 4'd0;
              phase     <= PH_SHIFT;
            end

            PH_SHIFT: begin
              if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
              end else begin
                div_cnt <= '0;
                if (!ser_clk) begin
                  ser_clk <= 1'b1;
                end else begin
                  ser_clk <= 1'b0;
                  if (bit_cnt == 4'd15) begin
                    shift_reg <= 16'h0000;
                    ser_cs_n  <= 1'b1;
                    phase     <= PH_GAP;
                  end else begin
                    bit_cnt   <= bit_cnt + 4'd1;
                    shift_reg <= {shift_reg[14:0], 1'b0};
                  end
                end
              end
            end

            PH_GAP: begin
              if (div_cnt != DIV_LAST) begin
                div_cnt <= div_cnt + 1'b1;
              end else begin
                div_cnt <= '0;
                phase   <= PH_LOAD;
                if (state == ST_INIT) begin
                  if (frame_idx == INIT_LAST) begin
                    frame_idx <= 3'd0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                  end else begin
                    frame_idx <= frame_idx + 3'd1;
                  end
                end else begin
                  // Advance the row here so the ROM address is settled
                  // for the whole cycle before the next LOAD. After row 7
                  // it wraps back to 0.
                  rom_row_idx <= rom_row_idx + 3'd1;
                  if (rom_row_idx == 3'd7) begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                  end
                end
              end
            end

            default: phase <= PH_LOAD;
          endcase
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
